// File: rtl/stopwatch_bcd_if.sv
// Stopwatch bundle: 1 ms strobe and raw buttons in, BCD display value and status out.
// Latency: none, plain wires.
// Backpressure: none; the display value is continuously valid.
interface stopwatch_bcd_if;
  logic        ce1ms;
  logic        btn_ss;
  logic        btn_clr;
  logic        btn_lap;
  logic [15:0] dat;
  logic        run;
  logic        ovf;

  modport master (output ce1ms, btn_ss, btn_clr, btn_lap, input dat, run, ovf);
  modport slave  (input ce1ms, btn_ss, btn_clr, btn_lap, output dat, run, ovf);
endinterface

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (SS.hh) with synchronised, debounced start/stop, clear and optional lap buttons.
// Latency: count visible on dat one clk after the qualifying ce1ms; button accepted on the DEB_MS-th stable ce1ms.
// Backpressure: none; dat/run/ovf are always valid. Optional lap hold enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int DEB_MS  = 20,
  parameter int TICK_MS = 10
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_bcd_if.slave sw
);

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam logic [7:0] DEB_LAST  = 8'(DEB_MS - 1);
  localparam logic [7:0] TICK_LAST = 8'(TICK_MS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  // Bit 0 start/stop, bit 1 clear, bit 2 lap (when present).
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_q;
  logic [NB-1:0] pulse;
  logic [7:0]    deb_cnt [NB];

  logic          p_ss;
  logic          p_clr;

  state_t        state;
  state_t        state_nxt;
  logic          clr_cnt;
  logic          cnt_en;

  logic [7:0]    presc;
  logic [15:0]   count;
  logic [16:0]   count_inc;
  logic          ovf_r;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {sw.btn_lap, sw.btn_clr, sw.btn_ss};
`else
  assign btn_raw = {sw.btn_clr, sw.btn_ss};
  logic unused_lap;
  assign unused_lap = sw.btn_lap;
`endif

  // Ripple-carry BCD increment; bit 16 is the carry out of the top digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Two-flop synchroniser for every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips after DEB_MS consecutive differing ce1ms samples; a matching sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      if (sw.ce1ms) begin
        for (int i = 0; i < NB; i++) begin
          if (sync2[i] == deb[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Press pulse: one cycle after the debounced level rises; releases give nothing.
  assign pulse = deb & ~deb_q;
  assign p_ss  = pulse[0];
  assign p_clr = pulse[1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus count controls; clear beats start/stop in STOP, both together in IDLE restart from zero.
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        clr_cnt = p_clr;
        if (p_ss) state_nxt = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        if (p_ss) state_nxt = STOP;
      end
      STOP: begin
        if (p_clr) begin
          state_nxt = IDLE;
          clr_cnt   = 1'b1;
        end else if (p_ss) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign count_inc = bcd_inc(count);

  // Prescaler and BCD count; a ce1ms in RUN counts even when start/stop fires in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else if (clr_cnt) begin
      presc <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else if (cnt_en && sw.ce1ms) begin
      if (presc == TICK_LAST) begin
        presc <= '0;
        count <= count_inc[15:0];
        if (count_inc[16]) ovf_r <= 1'b1;
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        hold;
  logic [15:0] hold_dat;

  // Lap hold: toggled by a lap press in RUN, snapshots the count on set, released on any clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= 1'b0;
      hold_dat <= '0;
    end else if (clr_cnt) begin
      hold <= 1'b0;
    end else if (state == RUN && pulse[2]) begin
      hold <= ~hold;
      if (!hold) hold_dat <= count;
    end
  end

  assign sw.dat = hold ? hold_dat : count;
`else
  assign sw.dat = count;
`endif

  assign sw.run = (state == RUN);
  assign sw.ovf = ovf_r;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed table, debounce/reset/wrap/lap sequences, randomized run against a model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_stopwatch_bcd;
  localparam int DEB  = 3;
  localparam int TICK = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_bcd_if if_a ();
  stopwatch_bcd_if if_b ();

  stopwatch_bcd #(.DEB_MS(DEB), .TICK_MS(TICK)) dut   (.clk(clk), .rst(rst), .sw(if_a));
  stopwatch_bcd #(.DEB_MS(1),   .TICK_MS(1))    dut_w (.clk(clk), .rst(rst), .sw(if_b));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model of the main instance: centiseconds as an integer, states as plain ints.
  int       m_state;   // 0 idle, 1 running, 2 stopped
  int       m_cs;
  int       m_ms;
  int       m_held;
  bit       m_hold;
  bit       m_ovf;
  bit [2:0] m_s1, m_s2, m_lvl, m_lvl_q, m_p;
  int       m_rl [3];

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10);
  endfunction

  function automatic logic [17:0] exp_vec();
    return {(m_hold ? to_bcd(m_held) : to_bcd(m_cs)), (m_state == 1), m_ovf};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_cs = 0; m_ms = 0; m_held = 0; m_hold = 0; m_ovf = 0;
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_q = 0;
      for (int i = 0; i < 3; i++) m_rl[i] = 0;
    end else begin
      m_p = m_lvl & ~m_lvl_q;
`ifndef STOPWATCH_LAP_EN
      m_p[2] = 1'b0;
`endif
      if (m_state == 0) begin
        if (m_p[1]) begin m_cs = 0; m_ovf = 0; m_ms = 0; m_hold = 0; end
        if (m_p[0]) m_state = 1;
      end else if (m_state == 1) begin
        if (m_p[2]) begin
          if (!m_hold) m_held = m_cs;
          m_hold = !m_hold;
        end
        if (if_a.ce1ms) begin
          m_ms++;
          if (m_ms == TICK) begin
            m_ms = 0;
            m_cs++;
            if (m_cs == 10000) begin m_cs = 0; m_ovf = 1; end
          end
        end
        if (m_p[0]) m_state = 2;
      end else begin
        if (m_p[1]) begin m_state = 0; m_cs = 0; m_ovf = 0; m_ms = 0; m_hold = 0; end
        else if (m_p[0]) m_state = 1;
      end
      m_lvl_q = m_lvl;
      if (if_a.ce1ms) begin
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] == m_lvl[i]) m_rl[i] = 0;
          else begin
            m_rl[i]++;
            if (m_rl[i] == DEB) begin m_lvl[i] = m_s2[i]; m_rl[i] = 0; end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {if_a.btn_lap, if_a.btn_clr, if_a.btn_ss};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobes(input int n);
    repeat (n) begin
      if_a.ce1ms = 1'b1; @(negedge clk);
      if_a.ce1ms = 1'b0; @(negedge clk);
    end
  endtask

  task automatic strobe_w(input int n);
    if_b.ce1ms = 1'b1; cyc(n);
    if_b.ce1ms = 1'b0; cyc(1);
  endtask

  // sel 0 = start/stop, 1 = clear on the wrap instance.
  task automatic press_w(input int sel);
    if (sel == 0) if_b.btn_ss = 1'b1; else if_b.btn_clr = 1'b1;
    cyc(3); strobe_w(1); cyc(3);
    if_b.btn_ss = 1'b0; if_b.btn_clr = 1'b0;
    cyc(3);
  endtask

  typedef struct {
    bit          ss;
    bit          clr;
    int          n;
    logic [15:0] dat;
    bit          run;
    bit          ovf;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 0,    3, 16'h0000, 1, 0};  // start from idle
    tbl[1]  = '{0, 0, 1234, 16'h0123, 1, 0};  // 1234 ms counted
    tbl[2]  = '{1, 0,    3, 16'h0123, 0, 0};  // stop, its strobes still count
    tbl[3]  = '{0, 0,   50, 16'h0123, 0, 0};  // stopped: frozen
    tbl[4]  = '{1, 0,    3, 16'h0123, 1, 0};  // resume, strobes not counted
    tbl[5]  = '{0, 0,   10, 16'h0124, 1, 0};  // prescaler preserved
    tbl[6]  = '{0, 1,    3, 16'h0125, 1, 0};  // clear ignored in run
    tbl[7]  = '{0, 0,    3, 16'h0125, 1, 0};
    tbl[8]  = '{1, 1,    3, 16'h0125, 0, 0};  // both in run: stop only
    tbl[9]  = '{0, 0,    3, 16'h0125, 0, 0};
    tbl[10] = '{1, 1,    3, 16'h0000, 0, 0};  // both in stop: clear wins
    tbl[11] = '{0, 0,    3, 16'h0000, 0, 0};
    tbl[12] = '{1, 1,    3, 16'h0000, 1, 0};  // both in idle: run from zero
    tbl[13] = '{0, 0,   25, 16'h0002, 1, 0};  // prescaler restarted from 0

    if_a.ce1ms = 0; if_a.btn_ss = 0; if_a.btn_clr = 0; if_a.btn_lap = 0;
    if_b.ce1ms = 0; if_b.btn_ss = 0; if_b.btn_clr = 0; if_b.btn_lap = 0;
    rst = 1'b1;
    cyc(3);
    check("reset_a", {14'd0, if_a.dat, if_a.run, if_a.ovf}, 32'h0);
    check("reset_b", {14'd0, if_b.dat, if_b.run, if_b.ovf}, 32'h0);
    rst = 1'b0;
    cyc(2);

    // Bouncing start press: 1-0-1-0 then a steady high.
    for (int b = 0; b < 4; b++) begin
      if_a.btn_ss = (b % 2 == 0); cyc(3); strobes(1);
    end
    if_a.btn_ss = 1'b1; cyc(3); strobes(2); cyc(3);
    check("deb_two_stable", {31'd0, if_a.run}, 32'd0);
    if_a.ce1ms = 1'b1; @(negedge clk); if_a.ce1ms = 1'b0;
    check("deb_pulse_cycle", {31'd0, if_a.run}, 32'd0);
    @(negedge clk);
    check("deb_run_rise", {31'd0, if_a.run}, 32'd1);
    strobes(22); cyc(3);
    check("deb_held", {31'd0, if_a.run}, 32'd1);
    if_a.btn_ss = 1'b0; cyc(3); strobes(10); cyc(3);
    check("deb_release", {31'd0, if_a.run}, 32'd1);
    check("deb_count", {16'd0, if_a.dat}, 32'h0003);

    // Asynchronous reset mid-count at 12.34.
    press_w(0);
    strobe_w(1234);
    check("w_1234", {14'd0, if_b.dat, if_b.run, if_b.ovf}, {14'd0, 16'h1234, 1'b1, 1'b0});
    @(posedge clk); #2 rst = 1'b1; #1;
    check("async_rst_b", {14'd0, if_b.dat, if_b.run, if_b.ovf}, 32'h0);
    check("async_rst_a", {14'd0, if_a.dat, if_a.run, if_a.ovf}, 32'h0);
    @(negedge clk); rst = 1'b0;
    cyc(20);
    check("post_rst_b", {14'd0, if_b.dat, if_b.run, if_b.ovf}, 32'h0);
    check("post_rst_a", {14'd0, if_a.dat, if_a.run, if_a.ovf}, 32'h0);

    // Directed table on the main instance.
    for (int i = 0; i < 14; i++) begin
      if_a.btn_ss = tbl[i].ss; if_a.btn_clr = tbl[i].clr;
      cyc(3); strobes(tbl[i].n); cyc(3);
      check($sformatf("vec%0d_dat", i), {16'd0, if_a.dat}, {16'd0, tbl[i].dat});
      check($sformatf("vec%0d_run", i), {31'd0, if_a.run}, {31'd0, tbl[i].run});
      check($sformatf("vec%0d_ovf", i), {31'd0, if_a.ovf}, {31'd0, tbl[i].ovf});
    end
    if_a.btn_ss = 0; if_a.btn_clr = 0;

    // Wrap from 99.99 on the fast instance.
    press_w(0);
    strobe_w(9999);
    check("wrap_9999", {14'd0, if_b.dat, if_b.run, if_b.ovf}, {14'd0, 16'h9999, 1'b1, 1'b0});
    strobe_w(1);
    check("wrap_0000", {14'd0, if_b.dat, if_b.run, if_b.ovf}, {14'd0, 16'h0000, 1'b1, 1'b1});
    press_w(0);
    check("wrap_stop", {14'd0, if_b.dat, if_b.run, if_b.ovf}, {14'd0, 16'h0001, 1'b0, 1'b1});
    press_w(1);
    check("wrap_clear", {14'd0, if_b.dat, if_b.run, if_b.ovf}, 32'h0);

`ifdef STOPWATCH_LAP_EN
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
    if_a.btn_ss = 1'b1; cyc(3); strobes(3); cyc(3); if_a.btn_ss = 1'b0;
    strobes(4997);
    if_a.btn_lap = 1'b1; cyc(3); strobes(3);
    check("lap_set", {16'd0, if_a.dat}, 32'h0500);
    if_a.btn_lap = 1'b0;
    for (int j = 0; j < 4; j++) begin
      strobes(50);
      check($sformatf("lap_hold%0d", j), {16'd0, if_a.dat}, 32'h0500);
    end
    if_a.btn_lap = 1'b1; cyc(3); strobes(3);
    check("lap_release", {16'd0, if_a.dat}, 32'h0520);
    if_a.btn_lap = 1'b0;
`endif

    // Randomized buttons and strobes against the model.
    for (int k = 0; k < 4000; k++) begin
      if_a.ce1ms = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) if_a.btn_ss  = ~if_a.btn_ss;
      if ($urandom_range(0, 79) == 0) if_a.btn_clr = ~if_a.btn_clr;
      if ($urandom_range(0, 29) == 0) if_a.btn_lap = ~if_a.btn_lap;
      @(negedge clk);
      check("rand", {14'd0, if_a.dat, if_a.run, if_a.ovf}, {14'd0, exp_vec()});
    end
    if_a.ce1ms = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit BCD stopwatch that generates the 16-bit value shown on the board's multiplexed seven-segment display. It consumes the display driver's `ce1ms` 1 ms strobe and feeds that driver's `dat[15:0]` input with the format SS.hh: seconds 00–99 and hundredths 00–99. Two push buttons control it: start/stop and clear. Both buttons are synchronised and debounced inside the block.

## Interface
Parameters:
- `DEB_MS`, default 20: number of consecutive stable `ce1ms` samples required to accept a button level change (range 1–255).
- `TICK_MS`, default 10: number of `ce1ms` strobes per least-significant-digit increment (range 1–255).

Ports:
- `clk`  in  1: system clock, rising edge. One clock; reset is asynchronous and active-high.
- `rst`  in  1: asynchronous active-high reset.
- `ce1ms`  in  1: one-cycle strobe every 1 ms, from the display driver.
- `btn_ss`  in  1: raw start/stop button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1: raw clear button, active-high, asynchronous.
- `btn_lap`  in  1: raw lap button, active-high. Used only with LAP_EN.
- `dat`  out  16: BCD display value. `[15:12]` tens of seconds, `[11:8]` seconds, `[7:4]` tenths, `[3:0]` hundredths.
- `run`  out  1: high while in RUN.
- `ovf`  out  1: sticky flag, set when the count wraps from 99.99.

## Operation
- Button path, identical for each button:
  - 2-FF synchroniser.
  - Debounce counter, sampled only on `ce1ms`. The debounced level changes after `DEB_MS` consecutive samples that differ from it. Any sample that matches the current debounced level resets the counter.
  - A rising edge of the debounced level produces a one-`clk` pulse (`p_ss`, `p_clr`, `p_lap`).
- State machine, with reset state IDLE:
  - IDLE: count is 0000. `p_ss` → RUN.
  - RUN: `p_ss` → STOP. `p_clr` is ignored.
  - STOP: `p_ss` → RUN (resume, prescaler is preserved). `p_clr` → IDLE.
  - `p_clr` in IDLE re-clears the count and `ovf`.
- Simultaneous pulses in STOP: `p_clr` wins and `p_ss` is dropped. In IDLE, `p_clr` and `p_ss` together → RUN with count 0000 and `ovf` cleared.
- Prescaler (8 bit):
  - Advances only in RUN, on `ce1ms`.
  - When it equals `TICK_MS-1` on a `ce1ms`, it reloads 0 and the BCD count increments.
  - Cleared on entry to IDLE.
- BCD increment: ripple-carry across 4 digits, each wrapping 9→0. 99.99 → 00.00 sets `ovf`. Counting continues after the wrap.
- Without lap hold, `dat` is the registered count.

## Timing
- Reset values: `dat`=16'h0000, `run`=0, `ovf`=0. All synchronisers, debounce counters and the prescaler are 0. Debounced levels are 0. State is IDLE.
- Press latency: a raw level change that is stable from a given point is accepted on the `DEB_MS`-th `ce1ms` after it reaches the synchroniser output (2 `clk`). The pulse is asserted in the cycle after that acceptance.
- The state change and `run` update register on the edge following the pulse.
- The count increment is visible on `dat` on the `clk` edge after the qualifying `ce1ms` cycle. Latency is 1 cycle.
- A `ce1ms` in the same cycle as `p_ss` (RUN→STOP) is still counted. A `ce1ms` coinciding with `p_ss` STOP→RUN is not counted.
- `rst` asserted mid-count forces every output to its reset value immediately, without waiting for a clock edge. Operation resumes from IDLE after deassertion.
- A button held for any length of time produces exactly one pulse. Release produces no pulse.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - Adds a third debouncer on `btn_lap` and a 16-bit hold register.
  - `p_lap` in RUN toggles `hold`. When `hold` is set, `dat` freezes at the count present at that edge while counting continues internally.
  - A second `p_lap` releases the hold, and `dat` tracks the count again from the next cycle.
  - `p_lap` in STOP or IDLE is ignored. The hold persists across RUN→STOP. Entry to IDLE releases it.
- `STOPWATCH_LAP_EN` undefined: `btn_lap` is ignored, no lap logic exists, and `dat` always equals the count.

## Test plan
Scenarios are listed as stimulus → required response.
- Reset/idle: assert `rst` mid-RUN with `dat`=12.34 → `dat`=0000, `run`=0, `ovf`=0 before the next clock edge. Release `rst` → stays 0000 with no presses.
- Debounce (`DEB_MS`=3): bounce `btn_ss` 1-0-1-0 on alternate ms, then hold high 5 ms → exactly one `p_ss`, on the 3rd stable `ce1ms`. `run` rises one cycle later.
- Counting (`TICK_MS`=10): start, then apply 1234 `ce1ms` strobes → `dat`=16'h0123. Stop, apply 50 strobes → unchanged. Resume, apply 10 strobes → 16'h0124.
- Wrap: run from 99.99 with one more tick → `dat`=0000, `ovf`=1. Stop, then clear → `ovf`=0, IDLE.
- Priority: in STOP, `p_clr` and `p_ss` in the same cycle → IDLE, `dat`=0000, `run`=0. Clear pressed during RUN → count unaffected.
- LAP_EN: in RUN at 05.00, lap press → `dat` holds 16'h0500 while 200 ms elapse. Second lap press → `dat`=16'h0520 next cycle.
